// File: rtl/ram_march_pkg.sv
// Shared types and helpers for the RAM march-test initiator.
package ram_march_pkg;

  // Deepest read latency the initiator and its compare delay line are built for.
  localparam int unsigned RdLatMax = 3;

  typedef enum logic [2:0] {
    StIdle,
    StPhW,
    StPhRw,
    StPhR,
    StDrain,
    StDone
  } march_state_e;

  // Background value for an address; callers size the result down to their data width.
  function automatic logic [31:0] bg(input logic [31:0] pattern, input logic [31:0] addr);
    return pattern ^ addr;
  endfunction

endpackage

// File: rtl/ram_march_cmp.sv
// Read-data checker: delays each read's {valid, addr, expected} tag by RD_LAT cycles so it
// lines up with the RAM's read data, compares, counts mismatches and captures the first one.
module ram_march_cmp #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_addr,
  input  logic [DATA_W-1:0] issue_exp,
  input  logic [DATA_W-1:0] rd_data,
  output logic              fail,
  output logic [7:0]        err_count,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_exp,
  output logic [DATA_W-1:0] fail_got
);

  logic [RD_LAT-1:0] dl_valid;
  logic [ADDR_W-1:0] dl_addr [RD_LAT];
  logic [DATA_W-1:0] dl_exp  [RD_LAT];
  logic              mismatch;

  // Last delay stage is aligned with the cycle in which rd_data is valid.
  always_comb begin
    mismatch = dl_valid[RD_LAT-1] && (rd_data != dl_exp[RD_LAT-1]);
  end

  // Tag delay line; stage 0 is fed from the registered read strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dl_valid <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        dl_addr[i] <= '0;
        dl_exp[i]  <= '0;
      end
    end else begin
      dl_valid[0] <= issue_valid;
      dl_addr[0]  <= issue_addr;
      dl_exp[0]   <= issue_exp;
      for (int i = 1; i < RD_LAT; i++) begin
        dl_valid[i] <= dl_valid[i-1];
        dl_addr[i]  <= dl_addr[i-1];
        dl_exp[i]   <= dl_exp[i-1];
      end
    end
  end

  // Sticky fail flag, saturating error count and first-failure capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fail      <= 1'b0;
      err_count <= '0;
      fail_addr <= '0;
      fail_exp  <= '0;
      fail_got  <= '0;
    end else if (clr) begin
      fail      <= 1'b0;
      err_count <= '0;
      fail_addr <= '0;
      fail_exp  <= '0;
      fail_got  <= '0;
    end else if (mismatch) begin
      fail <= 1'b1;
      if (err_count != 8'hFF) begin
        err_count <= err_count + 8'd1;
      end
      if (!fail) begin
        fail_addr <= dl_addr[RD_LAT-1];
        fail_exp  <= dl_exp[RD_LAT-1];
        fail_got  <= rd_data;
      end
    end
  end

endmodule

// File: rtl/ram_march_initiator.sv
// March-test initiator for the dual-port RAM: writes a background, read-checks it while
// writing the inverse, then read-checks the inverse descending. Reports pass/fail.
module ram_march_initiator
  import ram_march_pkg::*;
#(
  parameter int unsigned       ADDR_W  = 5,
  parameter int unsigned       DATA_W  = 8,
  parameter int unsigned       DEPTH   = 32,
  parameter int unsigned       RD_LAT  = 1,
  parameter logic [DATA_W-1:0] PATTERN = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_wr_en,
  output logic              mem_rd_en,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [7:0]        err_count,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_exp,
  output logic [DATA_W-1:0] fail_got
);

  localparam logic [ADDR_W-1:0] AddrLast  = ADDR_W'(DEPTH - 1);
  localparam logic [1:0]        SubLast   = 2'(RD_LAT);
  localparam logic [1:0]        DrainLast = 2'(RD_LAT - 1);

  march_state_e      state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        sub_q;     // PH_RW step within an address, reused as DRAIN counter
  logic [DATA_W-1:0] rd_exp_q;  // expected value travelling with the registered read strobe
  logic [DATA_W-1:0] bg_val;
  logic              accept;

  // Background value for the address currently held in the counter.
  always_comb begin
    bg_val = DATA_W'(bg(32'(PATTERN), 32'(addr_q)));
    accept = (state_q == StIdle) && start;
  end

  // Phase sequencer, address counter and all RAM-side/status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      sub_q       <= '0;
      rd_exp_q    <= '0;
      mem_addr    <= '0;
      mem_data_in <= '0;
      mem_wr_en   <= 1'b0;
      mem_rd_en   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      mem_wr_en <= 1'b0;
      mem_rd_en <= 1'b0;
      done      <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StPhW;
            busy    <= 1'b1;
            addr_q  <= '0;
          end
        end
        StPhW: begin
          mem_wr_en   <= 1'b1;
          mem_addr    <= addr_q;
          mem_data_in <= bg_val;
          if (addr_q == AddrLast) begin
            state_q <= StPhRw;
            addr_q  <= '0;
            sub_q   <= '0;
          end else begin
            addr_q <= addr_q + ADDR_W'(1);
          end
        end
        StPhRw: begin
          if (sub_q == 2'd0) begin
            mem_rd_en <= 1'b1;
            mem_addr  <= addr_q;
            rd_exp_q  <= bg_val;
          end
          // Inverse write lands in the same cycle the read data is valid.
          if (sub_q == SubLast) begin
            mem_wr_en   <= 1'b1;
            mem_addr    <= addr_q;
            mem_data_in <= ~bg_val;
            sub_q       <= '0;
            if (addr_q == AddrLast) begin
              state_q <= StPhR;
            end else begin
              addr_q <= addr_q + ADDR_W'(1);
            end
          end else begin
            sub_q <= sub_q + 2'd1;
          end
        end
        StPhR: begin
          mem_rd_en <= 1'b1;
          mem_addr  <= addr_q;
          rd_exp_q  <= ~bg_val;
          if (addr_q == '0) begin
            state_q <= StDrain;
            sub_q   <= '0;
          end else begin
            addr_q <= addr_q - ADDR_W'(1);
          end
        end
        StDrain: begin
          if (sub_q == DrainLast) begin
            state_q <= StDone;
          end else begin
            sub_q <= sub_q + 2'd1;
          end
        end
        StDone: begin
          done    <= 1'b1;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  ram_march_cmp #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_cmp (
    .clk         (clk),
    .rst         (rst),
    .clr         (accept),
    .issue_valid (mem_rd_en),
    .issue_addr  (mem_addr),
    .issue_exp   (rd_exp_q),
    .rd_data     (mem_data_out),
    .fail        (fail),
    .err_count   (err_count),
    .fail_addr   (fail_addr),
    .fail_exp    (fail_exp),
    .fail_got    (fail_got)
  );

endmodule
